parameterized_barrel_shifter: RTL and testbench
===============================================

Name: parameterized_barrel_shifter

Overview:
- Registered, parameterized barrel shifter/rotator for a 2**N-bit word.
- Shift/rotate amount is 0..2**N-1. Four operations are available: rotate right, rotate left, logical shift right, logical shift left.
- Datapath: N cascaded mux levels; level k conditionally moves the word by 2**k positions. One output register stage follows the levels.
- Used as a generic datapath utility (normalizers, bit-field extraction, demo/LED rotation logic).

Parameters:
- N, default 4: log2 of data width; number of mux levels; width of shift_amount.
- NUM_BITS, default 2**N: data width. Derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  qualifies in/shift_amount/op for capture this cycle
- in  input  NUM_BITS  data word to shift
- shift_amount  input  N  positions to move, unsigned 0..NUM_BITS-1
- op  input  2  00 rotate right, 01 rotate left, 10 logical shift right, 11 logical shift left
- out  output  NUM_BITS  registered result
- out_valid  output  1  out holds a result captured on the previous edge

Behaviour:
- Reset: on a clk rising edge with rst_n=0, out <= 0 and out_valid <= 0. Reset overrides in_valid in the same cycle.
- Latency: exactly 1 cycle. Inputs sampled at edge T with in_valid=1 appear on out with out_valid=1 after edge T.
- No backpressure: throughput is 1 result per cycle.
- in_valid=0 at an edge: out_valid <= 0 and out holds its previous value (no update).
- Combinational core: N levels. Level k uses shift_amount[k]. If that bit is 1, the level moves its input by 2**k positions in the op direction; if 0, it passes its input through.
- Rotate: bits shifted out at one end re-enter at the other end. No bits are lost.
- Logical shift: vacated positions fill with 0.
- shift_amount=0 for any op: out = in.
- Rotate by S equals rotate in the opposite direction by NUM_BITS-S.
- Maximum amount NUM_BITS-1:
  - a logical shift leaves only one surviving bit (in[MSB] for right, in[0] for left) at the far end;
  - a rotate is well defined.
- No latches. The core is fully combinational between input ports and the output register. out is driven only by the register.
- Width rules: shift_amount is treated as unsigned. No sign extension anywhere (arithmetic shift is not supported).

Decomposition:
- Shared package barrel_pkg: typedef enum logic [1:0] op_e {OP_ROR=2'b00, OP_ROL=2'b01, OP_SRL=2'b10, OP_SLL=2'b11}.
- Sub-module barrel_shift_level, parameterized by width W and distance D:
  - inputs: data, enable, op; output: data;
  - instantiated N times in a generate loop with D = 2**k.
- Top level holds the generate chain plus the valid/output register.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, in=16'hFFFF -> out=16'h0000, out_valid=0. Release reset -> first capture appears 1 cycle later.
- Rotate sweep: in=16'h8001, op=ROR, in_valid=1, shift_amount 0..15 on consecutive cycles -> out sequence 8001, C000, 6000, 3000, ..., 0003 at amount 15. out_valid=1 throughout, each result 1 cycle after its inputs.
- Rotate left: in=16'h8001, op=ROL, amount 1 -> 16'h0003; amount 4 -> 16'h0018. Cross-check against ROR with amount 15 and 12.
- Logical shifts: in=16'h8001, SRL amount 1 -> 16'h4000; SRL amount 15 -> 16'h0001; SLL amount 4 -> 16'h0010; SLL amount 15 -> 16'h8000.
- Valid gating: in_valid pattern 1,0,1 with distinct inputs -> out_valid 1,0,1 one cycle later. out holds the first result during the gap.
- Reset mid-stream: assert rst_n=0 during a continuous valid stream -> next edge out=0, out_valid=0. Pipeline resumes cleanly after release.

Source files
------------

// File: rtl/barrel_pkg.sv
// barrel_pkg: shared operation encoding for the barrel shifter datapath
//   op_e selects the direction and the kind of move:
//     OP_ROR rotate right, OP_ROL rotate left,
//     OP_SRL logical shift right (zero fill), OP_SLL logical shift left (zero fill)
package barrel_pkg;
    typedef enum logic [1:0] {
        OP_ROR = 2'b00,
        OP_ROL = 2'b01,
        OP_SRL = 2'b10,
        OP_SLL = 2'b11
    } op_e;
endpackage

// File: rtl/barrel_shift_level.sv
// barrel_shift_level: one mux level that moves a word by a fixed distance D
//   data    : W-bit word entering this level
//   enable  : when 1 move by D positions in the op direction, else pass through
//   op      : rotate/shift kind and direction
//   shifted : W-bit word leaving this level
module barrel_shift_level
    import barrel_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 1
) (
    input  logic [W-1:0] data,
    input  logic         enable,
    input  op_e          op,
    output logic [W-1:0] shifted
);
    logic [W-1:0] ror, rol, srl, sll, moved;
    // Rotates recirculate the bits that fall off one end into the other end.
    assign ror = {data[D-1:0], data[W-1:D]};
    assign rol = {data[W-D-1:0], data[W-1:W-D]};
    assign srl = data >> D;
    assign sll = data << D;
    always_comb begin
        moved   = op == OP_ROR ? ror :
                  op == OP_ROL ? rol :
                  op == OP_SRL ? srl : sll;
        shifted = enable ? moved : data;
    end
endmodule

// File: rtl/parameterized_barrel_shifter.sv
// parameterized_barrel_shifter: registered 2**N-bit barrel rotator / logical shifter
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset, clears out and out_valid
//   in_valid     : capture in/shift_amount/op on this edge
//   in           : data word to move
//   shift_amount : unsigned move distance 0..NUM_BITS-1
//   op           : 00 ror, 01 rol, 10 srl, 11 sll
//   out          : registered result, held while in_valid is low
//   out_valid    : out was captured on the previous edge
module parameterized_barrel_shifter
    import barrel_pkg::*;
#(
    parameter int N = 4,
    localparam int NUM_BITS = 2 ** N
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [NUM_BITS-1:0] in,
    input  logic [N-1:0]        shift_amount,
    input  logic [1:0]          op,
    output logic [NUM_BITS-1:0] out,
    output logic                out_valid
);
    logic [NUM_BITS-1:0] stage [0:N];
    assign stage[0] = in;
    // Level k contributes a move of 2**k when shift_amount[k] is set; the
    // moves compose because rotates and zero-fill shifts are additive.
    for (genvar k = 0; k < N; k++) begin : g_level
        barrel_shift_level #(
            .W (NUM_BITS),
            .D (2 ** k)
        ) u_level (
            .data    (stage[k]),
            .enable  (shift_amount[k]),
            .op      (op_e'(op)),
            .shifted (stage[k+1])
        );
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out <= stage[N];
        end
    end
endmodule

// File: tb/tb_parameterized_barrel_shifter.sv
// tb_parameterized_barrel_shifter: directed checks of the registered barrel shifter
module tb_parameterized_barrel_shifter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in = '0;
    logic [3:0]  shift_amount = '0;
    logic [1:0]  op = '0;
    logic [15:0] out;
    logic        out_valid;
    int passed = 0;
    int total = 0;
    localparam logic [1:0] ROR = 2'b00, ROL = 2'b01, SRL = 2'b10, SLL = 2'b11;
    logic [15:0] ror_sweep [16] = '{
        16'h8001, 16'hC000, 16'h6000, 16'h3000, 16'h1800, 16'h0C00, 16'h0600, 16'h0300,
        16'h0180, 16'h00C0, 16'h0060, 16'h0030, 16'h0018, 16'h000C, 16'h0006, 16'h0003
    };
    parameterized_barrel_shifter #(.N(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in           (in),
        .shift_amount (shift_amount),
        .op           (op),
        .out          (out),
        .out_valid    (out_valid)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic step(input logic r, input logic v, input logic [15:0] d, input logic [3:0] a,
                        input logic [1:0] o);
        rst_n = r;
        in_valid = v;
        in = d;
        shift_amount = a;
        op = o;
        @(posedge clk);
        #1;
    endtask
    task automatic expect_result(input string tag, input logic v, input logic [15:0] d);
        check({tag, " valid"}, {15'd0, out_valid}, {15'd0, v});
        check({tag, " out"}, out, d);
    endtask
    task automatic run(input string tag, input logic [15:0] d, input logic [3:0] a,
                       input logic [1:0] o, input logic [15:0] exp);
        step(1'b1, 1'b1, d, a, o);
        expect_result(tag, 1'b1, exp);
    endtask
    initial begin
        step(1'b0, 1'b1, 16'hFFFF, 4'd0, ROR);
        step(1'b0, 1'b1, 16'hFFFF, 4'd0, ROR);
        expect_result("reset", 1'b0, 16'h0000);
        for (int s = 0; s < 16; s++)
            run($sformatf("ror8001_%0d", s), 16'h8001, 4'(s), ROR, ror_sweep[s]);
        run("rol1", 16'h8001, 4'd1, ROL, 16'h0003);
        run("rol4", 16'h8001, 4'd4, ROL, 16'h0018);
        run("rol15", 16'h8001, 4'd15, ROL, 16'hC000);
        run("rol8", 16'h1234, 4'd8, ROL, 16'h3412);
        run("ror4", 16'hABCD, 4'd4, ROR, 16'hDABC);
        run("srl1", 16'h8001, 4'd1, SRL, 16'h4000);
        run("srl15", 16'h8001, 4'd15, SRL, 16'h0001);
        run("srl4", 16'hABCD, 4'd4, SRL, 16'h0ABC);
        run("sll4", 16'h8001, 4'd4, SLL, 16'h0010);
        run("sll15", 16'h8001, 4'd15, SLL, 16'h8000);
        run("sll0", 16'hA5A5, 4'd0, SLL, 16'hA5A5);
        run("srl0", 16'h5A5A, 4'd0, SRL, 16'h5A5A);
        run("gate1", 16'h1234, 4'd0, ROR, 16'h1234);
        step(1'b1, 1'b0, 16'hFFFF, 4'd3, ROL);
        expect_result("gate0", 1'b0, 16'h1234);
        run("gate2", 16'h00FF, 4'd8, SLL, 16'hFF00);
        run("stream_a", 16'h0F0F, 4'd4, ROL, 16'hF0F0);
        step(1'b0, 1'b1, 16'h0F0F, 4'd4, ROL);
        expect_result("midreset", 1'b0, 16'h0000);
        run("resume", 16'hC003, 4'd2, ROR, 16'hF000);
        run("resume2", 16'hC003, 4'd2, SRL, 16'h3000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
